// File: rtl/fft_r22sdf_twiddle_srv_pkg.sv
// ---------------------------------------------------------------------------
// fft_twiddle_pkg
// Shared definitions for the R22SDF twiddle server:
//   phase_e      - 3x-clock phase encodings (PH0/PH1/PH2; value 3 is illegal)
//   quad_e       - quadrant codes taken from the top two exponent bits
//   twiddle_max  - largest ROM magnitude, 2^(TW-1)-1, so negation never wraps
// ---------------------------------------------------------------------------
package fft_twiddle_pkg;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  function automatic int twiddle_max(input int tw);
    return (32'sd1 <<< (tw - 32'sd1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/fft_r22sdf_twiddle_srv_if.sv
// ---------------------------------------------------------------------------
// fft_r22sdf_twiddle_srv_if
// Request/response bundle between the three twiddle requesters and the
// server.
//   inv          - 1 = conjugate twiddle (inverse transform)
//   k0..k2       - exponent per requester, held for a full clk_i period
//   wX_re/wX_im  - signed twiddle per requester
//   valid        - outputs hold a published result
// Modports: master = requester side, slave = server side.
// ---------------------------------------------------------------------------
interface fft_r22sdf_twiddle_srv_if #(
  parameter int NLOG2         = 10,
  parameter int TWIDDLE_WIDTH = 10
);
  logic                            inv;
  logic [NLOG2-1:0]                k0;
  logic [NLOG2-1:0]                k1;
  logic [NLOG2-1:0]                k2;
  logic signed [TWIDDLE_WIDTH-1:0] w0_re;
  logic signed [TWIDDLE_WIDTH-1:0] w0_im;
  logic signed [TWIDDLE_WIDTH-1:0] w1_re;
  logic signed [TWIDDLE_WIDTH-1:0] w1_im;
  logic signed [TWIDDLE_WIDTH-1:0] w2_re;
  logic signed [TWIDDLE_WIDTH-1:0] w2_im;
  logic                            valid;

  modport master (
    output inv, k0, k1, k2,
    input  w0_re, w0_im, w1_re, w1_im, w2_re, w2_im, valid
  );

  modport slave (
    input  inv, k0, k1, k2,
    output w0_re, w0_im, w1_re, w1_im, w2_re, w2_im, valid
  );
endinterface

// File: rtl/fft_r22sdf_twiddle_srv_rom.sv
// ---------------------------------------------------------------------------
// fft_twiddle_rom
// Quarter-wave cosine table with two synchronous read ports, no data reset.
//   clk            - read clock
//   addr_a/addr_b  - read addresses
//   data_a/data_b  - registered read data (signed)
// The table round(max*cos(2*pi*m/FFT_N)) is generated at elaboration.
// ---------------------------------------------------------------------------
module fft_twiddle_rom
  import fft_twiddle_pkg::*;
#(
  parameter int    DEPTH     = 257,
  parameter int    WIDTH     = 10,
  parameter int    AW        = 9,
  parameter int    FFT_N     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic [AW-1:0]           addr_a,
  input  logic [AW-1:0]           addr_b,
  output logic signed [WIDTH-1:0] data_a,
  output logic signed [WIDTH-1:0] data_b
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  // Round half away from zero so the table is symmetric under negation.
  function automatic logic signed [WIDTH-1:0] cos_entry(input int m);
    real a;
    a = real'(twiddle_max(WIDTH)) *
        $cos(2.0 * 3.141592653589793 * real'(m) / real'(FFT_N));
    if (a >= 0.0) return WIDTH'($rtoi(a + 0.5));
    else          return WIDTH'($rtoi(a - 0.5));
  endfunction

  // Table image generation.
  initial begin
    for (int m = 0; m < DEPTH; m++) mem[m] = cos_entry(m);
  end

  // Dual synchronous read.
  always_ff @(posedge clk) begin
    data_a <= mem[addr_a];
    data_b <= mem[addr_b];
  end

endmodule

// File: rtl/fft_r22sdf_twiddle_srv.sv
// ---------------------------------------------------------------------------
// fft_r22sdf_twiddle_srv
// Twiddle source for the R22SDF stage multipliers. One quarter-wave ROM is
// time-shared on clk_3x_i by three requesters, one per 3x phase:
//   S1 captures k/inv, S2 reads the ROM, S3 folds quadrant/sign.
// All six outputs update together on the edge ending phase 1, one 3x cycle
// ahead of the clk_i edge that samples them.
//   clk_3x_i - 3x clock, phase 0 starts on the clk_i rising edge
//   rst_n    - synchronous active-low reset
//   bus      - slave side of fft_r22sdf_twiddle_srv_if
// ---------------------------------------------------------------------------
module fft_r22sdf_twiddle_srv
  import fft_twiddle_pkg::*;
#(
  parameter int    FFT_N         = 1024,
  parameter int    NLOG2         = 10,
  parameter int    TWIDDLE_WIDTH = 10,
  parameter string TWIDDLE_FILE  = "twiddle_q.hex"
) (
  input logic                    clk_3x_i,
  input logic                    rst_n,
  fft_r22sdf_twiddle_srv_if.slave bus
);

  localparam int MW      = NLOG2 - 2;  // in-quadrant index width
  localparam int AW      = NLOG2 - 1;  // ROM address width (0..N/4)
  localparam int QUARTER = FFT_N / 4;
  localparam int TW      = TWIDDLE_WIDTH;

  phase_e               phase_r, phase_nx;
  logic [NLOG2-1:0]     k_sel_s;
  logic                 hold0_en_s, hold1_en_s, publish_s;

  logic [NLOG2-1:0]     s1_k_r;
  logic                 s1_inv_r;
  quad_e                s2_q_r;
  logic                 s2_inv_r;
  logic [AW-1:0]        rom_addr_a_s, rom_addr_b_s;
  logic signed [TW-1:0] rom_a_s, rom_b_s;
  logic signed [TW-1:0] fold_re_s, fold_im_s;
  logic signed [TW-1:0] hold0_re_r, hold0_im_r, hold1_re_r, hold1_im_r;
  logic                 prime_r;

  assign rom_addr_a_s = {1'b0, s1_k_r[MW-1:0]};
  assign rom_addr_b_s = AW'(QUARTER) - rom_addr_a_s;

  fft_twiddle_rom #(
    .DEPTH     (QUARTER + 1),
    .WIDTH     (TW),
    .AW        (AW),
    .FFT_N     (FFT_N),
    .INIT_FILE (TWIDDLE_FILE)
  ) u_rom (
    .clk    (clk_3x_i),
    .addr_a (rom_addr_a_s),
    .addr_b (rom_addr_b_s),
    .data_a (rom_a_s),
    .data_b (rom_b_s)
  );

  // Phase counter state register.
  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) phase_r <= PH0;
    else        phase_r <= phase_nx;
  end

  // Phase sequencing and per-phase strobes; illegal phase 3 does nothing
  // and returns to PH0.
  always_comb begin
    phase_nx   = PH0;
    k_sel_s    = bus.k0;
    hold0_en_s = 1'b0;
    hold1_en_s = 1'b0;
    publish_s  = 1'b0;
    case (phase_r)
      PH0: begin
        phase_nx   = PH1;
        k_sel_s    = bus.k0;
        hold1_en_s = 1'b1;
      end
      PH1: begin
        phase_nx  = PH2;
        k_sel_s   = bus.k1;
        publish_s = prime_r;
      end
      PH2: begin
        phase_nx   = PH0;
        k_sel_s    = bus.k2;
        hold0_en_s = 1'b1;
      end
      default: begin
        phase_nx = PH0;
      end
    endcase
  end

  // S3 quadrant fold: rom_a = C(m), rom_b = C(N/4-m).
  always_comb begin
    fold_re_s = rom_a_s;
    fold_im_s = -rom_b_s;
    case (s2_q_r)
      Q0: begin fold_re_s = rom_a_s;  fold_im_s = -rom_b_s; end
      Q1: begin fold_re_s = -rom_b_s; fold_im_s = -rom_a_s; end
      Q2: begin fold_re_s = -rom_a_s; fold_im_s = rom_b_s;  end
      Q3: begin fold_re_s = rom_b_s;  fold_im_s = rom_a_s;  end
      default: begin fold_re_s = rom_a_s; fold_im_s = -rom_b_s; end
    endcase
    if (s2_inv_r) fold_im_s = -fold_im_s;
    else          fold_im_s = fold_im_s;
  end

  // Pipeline, hold registers and atomic publish. prime_r blocks publishing
  // until hold0 has been loaded from a post-reset request.
  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      s1_k_r     <= '0;
      s1_inv_r   <= 1'b0;
      s2_q_r     <= Q0;
      s2_inv_r   <= 1'b0;
      hold0_re_r <= '0;
      hold0_im_r <= '0;
      hold1_re_r <= '0;
      hold1_im_r <= '0;
      prime_r    <= 1'b0;
      bus.w0_re  <= '0;
      bus.w0_im  <= '0;
      bus.w1_re  <= '0;
      bus.w1_im  <= '0;
      bus.w2_re  <= '0;
      bus.w2_im  <= '0;
      bus.valid  <= 1'b0;
    end else begin
      s1_k_r   <= k_sel_s;
      s1_inv_r <= bus.inv;
      s2_q_r   <= quad_e'(s1_k_r[NLOG2-1 -: 2]);
      s2_inv_r <= s1_inv_r;
      if (hold0_en_s) begin
        hold0_re_r <= fold_re_s;
        hold0_im_r <= fold_im_s;
        prime_r    <= 1'b1;
      end
      if (hold1_en_s) begin
        hold1_re_r <= fold_re_s;
        hold1_im_r <= fold_im_s;
      end
      if (publish_s) begin
        bus.w0_re <= hold0_re_r;
        bus.w0_im <= hold0_im_r;
        bus.w1_re <= hold1_re_r;
        bus.w1_im <= hold1_im_r;
        bus.w2_re <= fold_re_s;
        bus.w2_im <= fold_im_s;
        bus.valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_r22sdf_twiddle_srv.sv
// ---------------------------------------------------------------------------
// tb_fft_r22sdf_twiddle_srv
// Driver issues one request group (k0,k1,k2 + per-requester inv) per clk_i
// period and pushes the expected six outputs, computed from full-circle
// cos/sin, into a queue. The monitor tracks the 3x phase, pops on each
// publish edge and checks all outputs on every 3x edge, so any change off
// the publish edge is caught too.
// ---------------------------------------------------------------------------
module tb_fft_r22sdf_twiddle_srv;
  import fft_twiddle_pkg::*;

  localparam int  N     = 1024;
  localparam int  NLOG2 = 10;
  localparam int  TW    = 10;
  localparam int  MAXV  = 511;
  localparam real PI    = 3.141592653589793;

  typedef logic [5:0][TW-1:0] exp_t;  // [0]=w0_re [1]=w0_im ... [5]=w2_im

  logic clk_3x = 1'b0;
  logic rst_n  = 1'b0;

  fft_r22sdf_twiddle_srv_if #(.NLOG2(NLOG2), .TWIDDLE_WIDTH(TW)) bus();

  fft_r22sdf_twiddle_srv #(
    .FFT_N(N), .NLOG2(NLOG2), .TWIDDLE_WIDTH(TW), .TWIDDLE_FILE("")
  ) dut (
    .clk_3x_i (clk_3x),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_3x = ~clk_3x;

  exp_t sb_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   ph_now    = 0;
  bit   ph_resync = 1'b0;
  bit   exp_known = 1'b1;
  bit   mon_stop  = 1'b0;

  function automatic int rnd(input real a);
    if (a >= 0.0) return $rtoi(a + 0.5);
    else          return $rtoi(a - 0.5);
  endfunction

  // W_N^k = cos(2*pi*k/N) - j sin(2*pi*k/N); conjugated when inverse.
  function automatic exp_t model(input int ka0, ka1, ka2, input bit iv0, iv1, iv2);
    exp_t e;
    int   ks[3];
    bit   ivs[3];
    real  th;
    int   re, im;
    ks  = '{ka0, ka1, ka2};
    ivs = '{iv0, iv1, iv2};
    for (int i = 0; i < 3; i++) begin
      th = 2.0 * PI * real'(ks[i]) / real'(N);
      re = rnd(real'(MAXV) * $cos(th));
      im = -rnd(real'(MAXV) * $sin(th));
      if (ivs[i]) im = -im;
      e[2*i]   = TW'(re);
      e[2*i+1] = TW'(im);
    end
    return e;
  endfunction

  function automatic exp_t pack6(input int a0, a1, a2, a3, a4, a5);
    exp_t e;
    e[0] = TW'(a0); e[1] = TW'(a1); e[2] = TW'(a2);
    e[3] = TW'(a3); e[4] = TW'(a4); e[5] = TW'(a5);
    return e;
  endfunction

  // Drive one group over a clk_i period; starts and ends on a negedge.
  task automatic issue(input int ka0, ka1, ka2, input bit iv0, iv1, iv2,
                       input bit use_given, input exp_t given);
    while (ph_now != 0) @(negedge clk_3x);
    bus.k0  = NLOG2'(ka0);
    bus.k1  = NLOG2'(ka1);
    bus.k2  = NLOG2'(ka2);
    bus.inv = iv0;
    @(negedge clk_3x);
    bus.inv = iv1;
    @(negedge clk_3x);
    bus.inv = iv2;
    if (use_given) sb_q.push_back(given);
    else           sb_q.push_back(model(ka0, ka1, ka2, iv0, iv1, iv2));
    @(negedge clk_3x);
  endtask

  task automatic issue_rand();
    issue($urandom_range(N-1), $urandom_range(N-1), $urandom_range(N-1),
          1'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0);
  endtask

  // Two reset edges; in-flight expectations are dropped.
  task automatic pulse_reset();
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk_3x);
    @(negedge clk_3x);
    rst_n = 1'b1;
  endtask

  // Monitor: phase tracking, scoreboard pop on publish edges, full compare.
  initial begin : monitor
    exp_t exp_w;
    exp_t act;
    bit   exp_v;
    int   ended;
    exp_w = '0;
    exp_v = 1'b0;
    forever begin
      @(posedge clk_3x);
      #1;
      if (!mon_stop) begin
        if (!rst_n) begin
          ph_now    = 0;
          exp_w     = '0;
          exp_v     = 1'b0;
          exp_known = 1'b1;
        end else if (ph_resync) begin
          ph_resync = 1'b0;
          ph_now    = 0;
          n_tests++;
          if (dut.phase_r !== PH0) begin
            n_fail++;
            $display("FAIL phase_recover: got %0d, required 0", dut.phase_r);
          end
        end else begin
          ended  = ph_now;
          ph_now = (ph_now + 1) % 3;
          if (ended == 1 && sb_q.size() > 0) begin
            exp_w     = sb_q.pop_front();
            exp_v     = 1'b1;
            exp_known = 1'b1;
          end
        end
        if (exp_known) begin
          act = {bus.w2_im, bus.w2_re, bus.w1_im, bus.w1_re, bus.w0_im, bus.w0_re};
          n_tests++;
          if (act !== exp_w || bus.valid !== exp_v) begin
            n_fail++;
            $display("FAIL outputs t=%0t: got v=%0b w0=(%0d,%0d) w1=(%0d,%0d) w2=(%0d,%0d), required v=%0b w0=(%0d,%0d) w1=(%0d,%0d) w2=(%0d,%0d)",
                     $time, bus.valid,
                     $signed(act[0]), $signed(act[1]), $signed(act[2]),
                     $signed(act[3]), $signed(act[4]), $signed(act[5]),
                     exp_v,
                     $signed(exp_w[0]), $signed(exp_w[1]), $signed(exp_w[2]),
                     $signed(exp_w[3]), $signed(exp_w[4]), $signed(exp_w[5]));
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin : driver
    bus.inv = 1'b0;
    bus.k0  = '0;
    bus.k1  = '0;
    bus.k2  = '0;
    repeat (3) @(negedge clk_3x);
    rst_n = 1'b1;

    issue(0, 256, 512, 1'b0, 1'b0, 1'b0, 1'b1, pack6(511, 0, 0, -511, -511, 0));
    issue(768, 128, 896, 1'b0, 1'b0, 1'b0, 1'b1, pack6(0, 511, 361, -361, 361, 361));
    issue(0, 256, 128, 1'b1, 1'b1, 1'b1, 1'b1, pack6(511, 0, 0, 511, 361, 361));
    issue(256, 128, 768, 1'b0, 1'b1, 1'b0, 1'b1, pack6(0, -511, 361, 361, 0, 511));
    repeat (20) issue_rand();

    for (int c = 0; c < N; c++) begin
      if (c == 500) pulse_reset();
      issue(c, (c + 341) % N, (c + 682) % N,
            1'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0);
    end

    // Illegal phase value must fall back to PH0 on the next edge.
    sb_q.delete();
    exp_known = 1'b0;
    ph_resync = 1'b1;
    force dut.phase_r = phase_e'(2'd3);
    #1;
    release dut.phase_r;
    @(negedge clk_3x);
    issue(128, 896, 256, 1'b0, 1'b0, 1'b1, 1'b1, pack6(361, -361, 361, 361, 0, 511));
    repeat (10) issue_rand();

    for (int i = 0; i < 12 && sb_q.size() != 0; i++) @(negedge clk_3x);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results, required 0", sb_q.size());
    end
    mon_stop = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_r22sdf_twiddle_srv.md
Name: fft_r22sdf_twiddle_srv

Overview:
- Twiddle-factor source for the R22SDF FFT: the producer feeding the w_re/w_im inputs of the stage twiddle multipliers.
- One quarter-wave cosine ROM is time-shared on clk_3x_i across three requesters, one per 3x phase, matching the 3-phase multiplier schedule.
- Each requester supplies exponent k and receives W_N^k = cos(2πk/N) − j·sin(2πk/N), or its conjugate when inv_i=1 (IFFT).

Parameters:
FFT_N, 1024, transform length (power of 2, ≥16)
NLOG2, 10, log2(FFT_N)
TWIDDLE_WIDTH, 10, signed output width
TWIDDLE_FILE, "twiddle_q.hex", $readmemh image of quarter-wave table

Ports:
clk_3x_i  in  1  3x clock, phase-locked to the FFT clk_i; phase 0 starts on the clk_i rising edge
rst_n  in  1  reset
inv_i  in  1  1 = return conjugate twiddle (inverse transform)
k0_i, k1_i, k2_i  in  NLOG2 each  exponent per requester, held stable for a full clk_i period
w0_re_o, w0_im_o, w1_re_o, w1_im_o, w2_re_o, w2_im_o  out  TWIDDLE_WIDTH each, signed  twiddle per requester
valid_o  out  1  outputs hold a published result

Behaviour:
- Reset (rst_n, synchronous, active-low, clock clk_3x_i):
  - Phase counter = 0; all pipeline regs = 0.
  - All w*_o = 0; valid_o = 0.
  - Reset asserted mid-operation: the same values are in place on the next edge, and in-flight requests are discarded.
- Phase counter: free-running 0→1→2→0; value 3 is illegal and recovers to 0.
- ROM contents: C(m) = round((2^(TWIDDLE_WIDTH−1)−1)·cos(2πm/N)), m = 0..N/4, depth N/4+1.
  - Maximum magnitude is 2^(TW−1)−1, so negation never overflows.
  - Synchronous dual read: port A at address m, port B at address N/4−m.
- Fold for k: q = k[NLOG2−1:NLOG2−2], m = k[NLOG2−3:0].
  - q=0: re=C(m), im=−C(N/4−m)
  - q=1: re=−C(N/4−m), im=−C(m)
  - q=2: re=−C(m), im=C(N/4−m)
  - q=3: re=C(N/4−m), im=C(m)
  - inv_i=1 negates im after folding.
- 3-stage pipeline: S1 capture k/inv, S2 ROM read, S3 sign/select into hold reg. Schedule per 3x edge ending phase p:
  - p=0: S1 captures k0.
  - p=1: S2 on k0, S1 captures k1.
  - p=2: S3 k0 → hold0; S2 on k1; S1 captures k2.
  - next p=0: hold1 ← k1; S2 on k2.
  - next p=1: publish all six outputs atomically (hold0, hold1, and k2's S3 result direct); valid_o ← 1.
- Outputs change only on the edge ending phase 1, giving one 3x cycle of setup before the clk_i edge. They are stable for the full clk_i period.
- Latency: k applied at clk_i edge n → result sampled at clk_i edge n+2 (6 clk_3x cycles).
- inv_i is sampled per requester at its own S1 capture.
- After rst_n deasserts, the first publish (valid_o=1) occurs on the 5th clk_3x edge.
- k = N/4, N/2, 3N/4 use m=0 and read address N/4 (C=0). No special-case logic.

Decomposition:
- Package fft_twiddle_pkg holds:
  - phase encodings PH0/PH1/PH2
  - quadrant codes Q0..Q3
  - function for the maximum magnitude 2^(TW−1)−1
- Sub-module fft_twiddle_rom: parameterised depth/width, two synchronous read ports, $readmemh init, no reset on the data path.

Test Plan (N=1024, TW=10, max=511):
- k0=0, k1=256, k2=512, inv=0 → w0=(511,0), w1=(0,−511), w2=(−511,0); valid_o=1 on the 5th edge after reset.
- k0=768, k1=128, k2=896, inv=0 → (0,511), (361,−361), (361,361); no crosstalk between requesters.
- k1=256, inv_i=1 → w1=(0,511); k1=128, inv_i=1 → (361,361).
- Change k every clk_i cycle (sweep 0..1023 on all three, offset by 0/341/682) → each output matches the golden cos/sin table exactly, 2 clk_i cycles later; outputs never change except on the edge ending phase 1.
- Assert rst_n low during sweep for 2 edges → next edge all outputs 0 and valid_o=0; valid_o returns on the 5th edge after release, carrying only post-reset requests.
- Force the phase counter to 3 → recovers to 0 on the next edge; a subsequent request returns the correct result.
